// File: rtl/mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_arbiter
// Description : Two-requester round-robin arbiter owning a 2:1 one-bit mux
//               select, with a one-cycle guard gap on every ownership change
//               and a registered, valid-qualified data output.
//               Optional hold timeout enabled by `define MUX2_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req_1,
    input  logic req_2,
    input  logic in_1,
    input  logic in_2,
    output logic grant_1,
    output logic grant_2,
    output logic select,
    output logic out,
    output logic out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_1 = 2'd1,
        GNT_2 = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    state_t     pick;
    logic [1:0] last;
    logic       timeout;

    if (HOLD_MAX < 2 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("mux2_arbiter: HOLD_MAX must be 2..15 and fit in CNT_W bits");
    end

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt;

    // Counter restarts on every grant entry and saturates once the owner has
    // used its full contended allowance.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_cnt <= '0;
        end else if ((next_state == GNT_1 && state != GNT_1) ||
                     (next_state == GNT_2 && state != GNT_2)) begin
            hold_cnt <= '0;
        end else if ((state == GNT_1 || state == GNT_2) && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign timeout = (hold_cnt == HOLD_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        pick       = IDLE;
        next_state = state;

        if (req_1 && req_2) begin
            pick = (last == 2'd2) ? GNT_1 : GNT_2;
        end else if (req_1) begin
            pick = GNT_1;
        end else if (req_2) begin
            pick = GNT_2;
        end

        case (state)
            IDLE, GUARD: begin
                next_state = pick;
            end
            GNT_1: begin
                if (req_1 && !(timeout && req_2)) begin
                    next_state = GNT_1;
                end else if (req_2) begin
                    next_state = GUARD;
                end else begin
                    next_state = IDLE;
                end
            end
            GNT_2: begin
                if (req_2 && !(timeout && req_1)) begin
                    next_state = GNT_2;
                end else if (req_1) begin
                    next_state = GUARD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grants and select are decoded from the next state so they line up
    // with the state register; data uses the grants already on the outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_1   <= 1'b0;
            grant_2   <= 1'b0;
            select    <= 1'b0;
            last      <= 2'd2;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            grant_1 <= (next_state == GNT_1);
            grant_2 <= (next_state == GNT_2);

            if (next_state == GNT_1) begin
                select <= 1'b1;
                last   <= 2'd1;
            end else if (next_state == GNT_2) begin
                select <= 1'b0;
                last   <= 2'd2;
            end

            if (grant_1) begin
                out <= in_1;
            end else if (grant_2) begin
                out <= in_2;
            end
            out_valid <= grant_1 | grant_2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_arbiter
// Description : Self-checking bench for mux2_arbiter against an ownership
//               model, with directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_arbiter;

    localparam int HOLD_MAX = 8;
`ifdef MUX2_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic req_1 = 1'b0;
    logic req_2 = 1'b0;
    logic in_1  = 1'b0;
    logic in_2  = 1'b0;
    logic grant_1, grant_2, select, dout, out_valid;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    // Model: who owns the datapath and for how many cycles it has held it.
    int   m_owner = 0;
    int   m_last  = 2;
    int   m_run   = 0;
    logic m_sel   = 1'b0;
    logic m_out   = 1'b0;
    logic m_valid = 1'b0;

    mux2_arbiter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .req_1     (req_1),
        .req_2     (req_2),
        .in_1      (in_1),
        .in_2      (in_2),
        .grant_1   (grant_1),
        .grant_2   (grant_2),
        .select    (select),
        .out       (dout),
        .out_valid (out_valid)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic r1, input logic r2, input int last);
        if (r1 && r2) return (last == 2) ? 1 : 2;
        if (r1) return 1;
        if (r2) return 2;
        return 0;
    endfunction

    // A released grant always leaves one owner-less cycle; from an owner-less
    // cycle the requests are resolved by round-robin.
    always @(posedge clk or posedge rst) begin : model
        int   o;
        int   r;
        int   l;
        logic s;
        logic mine;
        logic other;
        if (rst) begin
            m_owner <= 0;
            m_last  <= 2;
            m_run   <= 0;
            m_sel   <= 1'b0;
            m_out   <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            o = m_owner;
            r = m_run;
            l = m_last;
            s = m_sel;
            if (o != 0) begin
                mine  = (o == 1) ? req_1 : req_2;
                other = (o == 1) ? req_2 : req_1;
                if (mine && !(TIMEOUT_ON && other && r >= HOLD_MAX)) r = r + 1;
                else o = 0;
            end else begin
                o = pick(req_1, req_2, l);
                if (o != 0) begin
                    l = o;
                    r = 1;
                    s = (o == 1);
                end
            end
            m_owner <= o;
            m_run   <= r;
            m_last  <= l;
            m_sel   <= s;
            m_out   <= (m_owner == 1) ? in_1 : (m_owner == 2) ? in_2 : m_out;
            m_valid <= (m_owner != 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("grant_1", grant_1, m_owner == 1);
            chk("grant_2", grant_2, m_owner == 2);
            chk("select", select, m_sel);
            chk("out", dout, m_out);
            chk("out_valid", out_valid, m_valid);
            chk("exclusive", grant_1 & grant_2, 0);
        end
    end

    initial begin
        logic sv;
        int   p;
        // Reset without any clock edge
        #1;
        rst   = 1'b1;
        req_1 = 1'($urandom);
        req_2 = 1'($urandom);
        #1;
        chk("rst_grant_1", grant_1, 0);
        chk("rst_grant_2", grant_2, 0);
        chk("rst_select", select, 0);
        chk("rst_out", dout, 0);
        chk("rst_valid", out_valid, 0);
        cmp_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_g1", grant_1, 0);
            chk("rst_hold_g2", grant_2, 0);
            req_1 = 1'($urandom);
            req_2 = 1'($urandom);
        end

        // Single requester with toggling data
        @(negedge clk);
        rst   = 1'b0;
        req_1 = 1'b1;
        req_2 = 1'b0;
        in_1  = 1'b0;
        sv    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("single_g1", grant_1, 1);
                chk("single_sel", select, 1);
            end else begin
                chk("single_out", dout, sv);
                chk("single_valid", out_valid, 1);
            end
            chk("single_g2", grant_2, 0);
            in_1 = ~in_1;
            sv   = in_1;
            if (k == 4) req_2 = 1'b1;
        end

        // Handover on release
        @(negedge clk);
        chk("hand_pre_g1", grant_1, 1);
        req_1 = 1'b0;
        in_2  = 1'b1;
        @(negedge clk);
        chk("hand_gap_g1", grant_1, 0);
        chk("hand_gap_g2", grant_2, 0);
        chk("hand_gap_valid", out_valid, 1);
        @(negedge clk);
        chk("hand_g2", grant_2, 1);
        chk("hand_sel", select, 0);
        chk("hand_valid_low", out_valid, 0);
        @(negedge clk);
        chk("hand_valid_back", out_valid, 1);
        chk("hand_out", dout, 1);
        in_2 = 1'b0;
        @(negedge clk);
        chk("hand_out2", dout, 0);

        // Asynchronous reset pulse mid-grant
        #2 rst = 1'b1;
        #1;
        chk("async_g2", grant_2, 0);
        chk("async_g1", grant_1, 0);
        chk("async_valid", out_valid, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("async_regrant_g2", grant_2, 1);

        // Contention from idle with last = 2
        req_2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_1 = 1'b1;
        req_2 = 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            p = i % 18;
            chk("cont_g1", grant_1, p < 8);
            chk("cont_g2", grant_2, p >= 9 && p < 17);
            if (p >= 9 && p < 17) chk("cont_sel", select, 0);
        end
        req_1 = 1'b0;
        req_2 = 1'b0;
`else
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("cont_g1", grant_1, 1);
            chk("cont_g2", grant_2, 0);
        end
        req_1 = 1'b0;
        @(negedge clk);
        chk("cont_gap_g1", grant_1, 0);
        chk("cont_gap_g2", grant_2, 0);
        @(negedge clk);
        chk("cont_g2_after", grant_2, 1);
        chk("cont_sel_after", select, 0);
        req_2 = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req_1 = ~req_1;
            if ($urandom_range(3) == 0) req_2 = ~req_2;
            in_1 = 1'($urandom);
            in_2 = 1'($urandom);
            if ($urandom_range(149) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester round-robin arbiter that time-shares one 2:1 one-bit mux datapath between two requesters. It owns the mux `select` line, issues exclusive grants, inserts a one-cycle guard gap on every ownership change, and registers the selected data with a valid flag. It sits directly in front of `mux2_1`; the `select` output drives the mux select, and `out`/`out_valid` feed the downstream consumer.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while the other side is requesting. Legal range 2..15. Used only with the timeout feature.
- `CNT_W`, default 4: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX.
- `sys_clk`  in  1  single clock, all logic on rising edge.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `req_1`  in  1  requester 1 wants the datapath (level).
- `req_2`  in  1  requester 2 wants the datapath (level).
- `in_1`  in  1  requester 1 data.
- `in_2`  in  1  requester 2 data.
- `grant_1`  out  1  requester 1 owns the datapath.
- `grant_2`  out  1  requester 2 owns the datapath.
- `select`  out  1  mux select: 1 routes `in_1`, 0 routes `in_2`.
- `out`  out  1  registered selected data.
- `out_valid`  out  1  `out` carries owner data this cycle.

## Operation
- FSM states: IDLE, GNT_1, GNT_2, GUARD. All outputs are registered, and at most one grant is high at any time.
- `last` register records the previous owner. Reset value: 2, so requester 1 wins the first tie.
- IDLE, or exit from GUARD:
  - only `req_1` → GNT_1.
  - only `req_2` → GNT_2.
  - both → grant the side that is not `last`.
  - none → IDLE.
- GNT_x:
  - stays while `req_x`=1 and no timeout.
  - if `req_x`=0 and the other side is requesting → GUARD.
  - if `req_x`=0 and the other side is not requesting → IDLE.
  - on entry, `last`←x and `hold_cnt`←0.
- GUARD: exactly one cycle. Both grants are 0, `select` is held, and arbitration then runs per the IDLE rules.
- `select` is loaded on entry to GNT_1 (1) or GNT_2 (0). It holds its value in IDLE and GUARD.
- Data path, each edge:
  - `out` ← `in_1` if `grant_1`, `in_2` if `grant_2`, else holds.
  - `out_valid` ← `grant_1 | grant_2`.
- Reset values: state IDLE, `grant_1`=0, `grant_2`=0, `select`=0, `out`=0, `out_valid`=0, `hold_cnt`=0, `last`=2.

## Timing
- Request to grant: a request sampled at edge N gives the grant high after edge N, provided the FSM is in IDLE.
- Grant to data: data sampled at edge N+1 appears on `out` with `out_valid`=1 after edge N+1.
- Release: `req_x` low at edge M clears `grant_x` after edge M. `out_valid` falls one edge later.
- Handover: two edges from the owner's release (or timeout) to the new grant, with exactly one all-zero grant cycle between them.
- Simultaneous first requests from IDLE resolve by `last`. No cycle has both grants high.
- A request dropped during GUARD is simply not granted. If neither side is requesting at GUARD exit, the FSM goes to IDLE.
- Reset asserted mid-grant forces all reset values immediately, without waiting for a clock edge. Release is sampled at the next edge, and arbitration restarts from IDLE with `last`=2.

## Configuration
- Macro: `MUX2_ARB_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` increments each GNT_x cycle and saturates at HOLD_MAX-1.
  - when `hold_cnt`=HOLD_MAX-1 and the other side is requesting, GNT_x → GUARD. The owner is therefore granted for at most HOLD_MAX cycles under contention.
  - when `hold_cnt`=HOLD_MAX-1 with no competitor, the grant continues and the counter stays saturated until the grant ends.
- Undefined: no counter logic is instantiated, and the owner holds the grant until its request drops. Latency and all other behaviour are identical.

## Test plan
- Reset: `sys_rst`=1 with random requests → `grant_1`, `grant_2`, `select`, `out`, `out_valid` all 0 without any clock edge. They remain 0 while `sys_rst` stays high.
- Single requester: `req_1`=1 from edge 0 with `in_1` toggling → `grant_1`=1 and `select`=1 after edge 0. `out` equals the previous-edge `in_1` with `out_valid`=1 from edge 1 on. `grant_2` stays 0.
- Contention with macro defined, HOLD_MAX=8, both requests held:
  - `grant_1` high for 8 cycles, then 1 guard cycle.
  - `grant_2` high for 8 cycles with `select`=0, then 1 guard cycle.
  - `grant_1` resumes. Period is 18 cycles.
- Contention with macro undefined, both requests held for 50 cycles → `grant_1` high for all 50 cycles. After `req_1` drops: one guard cycle, then `grant_2`=1.
- Handover on release: owner 1, `req_2`=1, `req_1` drops at edge M → grants 0 after M, `grant_2`=1 and `select`=0 after M+1. `out_valid` is 0 for exactly one cycle.
- Async reset mid-grant: `sys_rst` pulsed between edges during `grant_2` → grants clear immediately. After release with only `req_2`=1 → `grant_2`=1 after the first sampling edge.
